// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared constants and types for the gate truth-table sweeper
// Contents: gate function codes, the golden 28-bit truth table, sweeper state enum,
//           and a helper returning one golden nibble.
package gate_pkg;

    localparam logic [2:0] FN_AND  = 3'd0;
    localparam logic [2:0] FN_OR   = 3'd1;
    localparam logic [2:0] FN_NOTB = 3'd2;
    localparam logic [2:0] FN_NAND = 3'd3;
    localparam logic [2:0] FN_NOR  = 3'd4;
    localparam logic [2:0] FN_XOR  = 3'd5;
    localparam logic [2:0] FN_XNOR = 3'd6;

    // Nibble f holds the expected y for fn=f, indexed by {a,b}; lowest fn in the low nibble.
    localparam logic [27:0] GOLDEN_TT = 28'h96175E8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] golden_nibble(input int unsigned f);
        return GOLDEN_TT[f*4 +: 4];
    endfunction

endpackage

// File: rtl/tag_delay.sv
// rtl/tag_delay.sv - valid+data shift pipeline for latency matching
// Ports: clk, rst_n (async active-low), in_valid/in_data (enter stage 0),
//        out_valid/out_data (leave stage DEPTH-1, DEPTH edges after entry).
module tag_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/gate_tt_sweeper.sv
// rtl/gate_tt_sweeper.sv - sweeps every (fn,a,b) through the gate unit and checks the truth table
// Ports: clk, rst_n (async active-low), start (honoured in IDLE only),
//        a/b/fn (registered drive to gate unit), y (registered gate result),
//        busy, done (1-cycle pulse), tt (captured table), mismatch (per-fn nibble error), pass.
module gate_tt_sweeper
    import gate_pkg::*;
#(
    parameter int NUM_FN   = 7,
    parameter int GATE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  a,
    output logic                  b,
    output logic [2:0]            fn,
    input  logic                  y,
    output logic                  busy,
    output logic                  done,
    output logic [4*NUM_FN-1:0]   tt,
    output logic [NUM_FN-1:0]     mismatch,
    output logic                  pass
);

    localparam int TT_W  = 4 * NUM_FN;
    localparam int IDX_W = $clog2(TT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TT_W - 1);

    state_t state, state_next;

    logic [IDX_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  cap_cnt;
    logic              cap_valid;
    logic [IDX_W-1:0]  cap_idx;
    logic [TT_W-1:0]   tt_cap;
    logic [NUM_FN-1:0] mismatch_calc;
    logic              final_cap;

    // One extra stage over GATE_LAT: the gate samples a/b/fn one edge after we drive them.
    tag_delay #(
        .DEPTH (GATE_LAT + 1),
        .WIDTH (IDX_W)
    ) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state == RUN),
        .in_data   (issue_cnt),
        .out_valid (cap_valid),
        .out_data  (cap_idx)
    );

    assign final_cap = cap_valid && (cap_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (issue_cnt == LAST_IDX) state_next = DRAIN;
            DRAIN:   if (final_cap) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // Table including this cycle's capture, so the verdict can be formed on the final capture edge.
    always_comb begin
        tt_cap = tt;
        if (cap_valid) begin
            tt_cap[cap_idx] = y;
        end
    end

    always_comb begin
        mismatch_calc = '0;
        for (int f = 0; f < NUM_FN; f++) begin
            mismatch_calc[f] = (tt_cap[f*4 +: 4] != golden_nibble(f));
        end
    end

    // Datapath: issue, capture and verdict registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= 1'b0;
            b         <= 1'b0;
            fn        <= 3'd0;
            tt        <= '0;
            mismatch  <= '0;
            pass      <= 1'b0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
        end else begin
            if (state == IDLE && start) begin
                tt        <= '0;
                mismatch  <= '0;
                pass      <= 1'b0;
                issue_cnt <= '0;
                cap_cnt   <= '0;
            end
            if (state == RUN) begin
                fn        <= 3'(issue_cnt >> 2);
                a         <= issue_cnt[1];
                b         <= issue_cnt[0];
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (cap_valid) begin
                tt      <= tt_cap;
                cap_cnt <= cap_cnt + 1'b1;
            end
            if (state == DRAIN && final_cap) begin
                mismatch <= mismatch_calc;
                pass     <= ~|mismatch_calc;
            end
        end
    end

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// tb/tb_gate_tt_sweeper.sv - directed self-checking bench for gate_tt_sweeper
module tb_gate_tt_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic fault;

    // Latency-1 instance
    logic        start1, a1, b1, y1, busy1, done1, pass1;
    logic [2:0]  fn1;
    logic [27:0] tt1;
    logic [6:0]  mm1;

    // Latency-3 instance
    logic        start3, a3, b3, y3, busy3, done3, pass3;
    logic [2:0]  fn3;
    logic [27:0] tt3;
    logic [6:0]  mm3;
    logic [2:0]  y3_pipe;

    int checks = 0;
    int errors = 0;

    gate_tt_sweeper #(.NUM_FN(7), .GATE_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .fn(fn1), .y(y1),
        .busy(busy1), .done(done1), .tt(tt1), .mismatch(mm1), .pass(pass1)
    );

    gate_tt_sweeper #(.NUM_FN(7), .GATE_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .fn(fn3), .y(y3),
        .busy(busy3), .done(done3), .tt(tt3), .mismatch(mm3), .pass(pass3)
    );

    function automatic logic gate_eval(input logic [2:0] f, input logic ai, input logic bi,
                                       input logic flt);
        case (f)
            3'd0:    return ai & bi;
            3'd1:    return ai | bi;
            3'd2:    return ~bi;
            3'd3:    return ~(ai & bi);
            3'd4:    return ~(ai | bi);
            3'd5:    return flt ? (ai | bi) : (ai ^ bi);
            3'd6:    return ~(ai ^ bi);
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1      <= 1'b0;
            y3_pipe <= '0;
        end else begin
            y1      <= gate_eval(fn1, a1, b1, fault);
            y3_pipe <= {y3_pipe[1:0], gate_eval(fn3, a3, b3, 1'b0)};
        end
    end
    assign y3 = y3_pipe[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start on dut1 and watches up to 45 edges after the accepting edge.
    task automatic sweep1(input bit order_chk, output int done_edge, output int done_cnt,
                          output logic busy_at_done);
        done_edge = -1;
        done_cnt = 0;
        busy_at_done = 1'bx;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("busy_rise", busy1, 1'b1);
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk);
            #1;
            if (order_chk && n <= 28) begin
                check("issue_order", {fn1, a1, b1}, 64'(n - 1));
                check("fn_not_7", (fn1 == 3'd7), 1'b0);
            end
            if (order_chk && (n == 29 || n == 30)) begin
                check("drain_hold", {fn1, a1, b1}, 64'd27);
            end
            if (done1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = n;
                    busy_at_done = busy1;
                end
            end
        end
    endtask

    int   de, dc, de2, dc_win;
    logic bd;

    initial begin
        rst_n  = 1'b0;
        fault  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {a1, b1, fn1, busy1, done1, tt1, mm1, pass1}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct gate, with issue-order monitoring
        sweep1(1'b1, de, dc, bd);
        check("done_edge", 64'(de), 64'd30);
        check("done_count", 64'(dc), 64'd1);
        check("busy_at_done", bd, 1'b0);
        check("tt_good", tt1, 28'h96175E8);
        check("mismatch_good", mm1, 7'd0);
        check("pass_good", pass1, 1'b1);

        // Faulty gate: XOR behaves as OR
        fault = 1'b1;
        sweep1(1'b0, de, dc, bd);
        fault = 1'b0;
        check("fault_done_edge", 64'(de), 64'd30);
        check("fault_xor_nibble", tt1[23:20], 4'hE);
        check("fault_tt", tt1, 28'h9E175E8);
        check("fault_mismatch", mm1, 7'b0100000);
        check("fault_pass", pass1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("tt_hold", tt1, 28'h9E175E8);

        // start held high for 40 edges (edge 0 .. edge 39)
        de = -1;
        de2 = -1;
        dc_win = 0;
        @(negedge clk);
        start1 = 1'b1;
        for (int n = 0; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 39) start1 = 1'b0;
            if (n == 31) check("held_idle_busy", busy1, 1'b0);
            if (n == 32) check("held_restart_busy", busy1, 1'b1);
            if (done1) begin
                if (n <= 39) dc_win++;
                if (de < 0) de = n;
                else if (de2 < 0) de2 = n;
            end
        end
        check("held_done_in_window", 64'(dc_win), 64'd1);
        check("held_first_done", 64'(de), 64'd30);
        check("held_second_done", 64'(de2), 64'd62);
        check("held_pass", pass1, 1'b1);

        // Reset at edge 12 of a sweep
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midsweep_reset", {a1, b1, fn1, busy1, done1, tt1, mm1, pass1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done1) dc++;
        end
        check("no_done_after_abort", 64'(dc), 64'd0);
        sweep1(1'b0, de, dc, bd);
        check("post_reset_done_edge", 64'(de), 64'd30);
        check("post_reset_pass", pass1, 1'b1);
        check("post_reset_tt", tt1, 28'h96175E8);

        // Latency-3 gate
        de = -1;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk);
            #1;
            if (done3 && de < 0) de = n;
        end
        check("lat3_done_edge", 64'(de), 64'd32);
        check("lat3_tt", tt3, 28'h96175E8);
        check("lat3_pass", pass3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
